// File: rtl/gelato_types.sv
// rtl/gelato_types.sv - shared widths, types and entry layout for the SIMT split table
package gelato_types;

  localparam int GELATO_WARP_NUM    = 4;
  localparam int GELATO_THREAD_NUM  = 32;
  localparam int GELATO_SPLIT_DEPTH = 8;
  localparam int GELATO_ADDR_WIDTH  = 32;
  localparam int GELATO_WARP_W      = $clog2(GELATO_WARP_NUM);
  localparam int GELATO_SPLIT_W     = $clog2(GELATO_SPLIT_DEPTH);

  typedef logic [GELATO_WARP_W-1:0]     warp_num_t;
  typedef logic [GELATO_SPLIT_W-1:0]    split_table_num_t;
  typedef logic [GELATO_THREAD_NUM-1:0] thread_mask_t;
  typedef logic [GELATO_ADDR_WIDTH-1:0] addr_t;

  typedef struct packed {
    logic         valid;
    thread_mask_t mask;
    addr_t        reconv_pc;
  } split_entry_t;

  localparam split_table_num_t GELATO_SPLIT_TOP = split_table_num_t'(GELATO_SPLIT_DEPTH - 1);

  // A split that leaves either side empty creates no new path.
  function automatic logic is_degenerate(input thread_mask_t eff, input thread_mask_t parent);
    return (eff == '0) || (eff == parent);
  endfunction

endpackage

// File: rtl/gelato_split_stack.sv
// rtl/gelato_split_stack.sv - per-warp divergence stack: entries, stack pointer, push/pop
module gelato_split_stack
  import gelato_types::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  split_table_num_t lookup_idx,
  output thread_mask_t     lookup_mask,
  input  logic             pop_req,
  input  addr_t            pop_pc,
  output logic             pop_fire,
  output logic             full,
  input  logic             push_en,
  input  thread_mask_t     push_mask,
  input  addr_t            push_pc,
  output split_table_num_t push_entry_num
`ifdef GELATO_SPLIT_TABLE_ERR_EN
  , output logic           err_hit
`endif
);

  split_table_num_t                           sp;
  split_table_num_t                           sp_inc;
  split_table_num_t                           sp_dec;
  split_entry_t [GELATO_SPLIT_DEPTH-1:0]      entries;
  split_entry_t                               sel;
  thread_mask_t                               top_mask;
  thread_mask_t                               eff;
  logic                                       degenerate;
  logic                                       pc_match;

  assign sp_inc     = sp + split_table_num_t'(1);
  assign sp_dec     = sp - split_table_num_t'(1);
  assign sel        = entries[lookup_idx];
  assign top_mask   = entries[sp].mask;
  assign lookup_mask = sel.valid ? sel.mask : '0;
  assign pc_match   = (pop_pc == sel.reconv_pc);

  // Only the innermost split may reconverge, and only at its own PC.
  assign pop_fire   = pop_req & (lookup_idx != '0) & sel.valid & (lookup_idx == sp) & pc_match;
  assign full       = (sp == GELATO_SPLIT_TOP);

  assign eff            = push_mask & top_mask;
  assign degenerate     = is_degenerate(eff, top_mask);
  assign push_entry_num = degenerate ? sp : sp_inc;

`ifdef GELATO_SPLIT_TABLE_ERR_EN
  assign err_hit = pop_req & (((lookup_idx != '0) & sel.valid & (lookup_idx != sp) & pc_match)
                              | !sel.valid);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
      for (int i = 0; i < GELATO_SPLIT_DEPTH; i++) begin
        entries[i].valid     <= (i == 0);
        entries[i].mask      <= {GELATO_THREAD_NUM{i == 0}};
        entries[i].reconv_pc <= '0;
      end
    end else if (pop_fire) begin
      entries[sp_dec].mask <= entries[sp_dec].mask | top_mask;
      entries[sp]          <= '0;
      sp                   <= sp_dec;
    end else if (push_en && !degenerate) begin
      entries[sp_inc] <= '{valid: 1'b1, mask: eff, reconv_pc: push_pc};
      entries[sp].mask <= top_mask & ~eff;
      sp              <= sp_inc;
    end
  end

endmodule

// File: rtl/gelato_split_table.sv
// rtl/gelato_split_table.sv - SIMT split table top; GELATO_SPLIT_TABLE_ERR_EN adds sticky split_err
module gelato_split_table
  import gelato_types::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  warp_num_t        id_warp_num,
  input  split_table_num_t id_split_table_num,
  output thread_mask_t     id_thread_mask,
  input  logic             id_valid,
  input  logic             id_stall,
  input  addr_t            id_updated_pc,
  input  logic             split_valid,
  output logic             split_ready,
  input  warp_num_t        split_warp_num,
  input  thread_mask_t     split_mask,
  input  addr_t            split_reconv_pc,
  output logic             split_done,
  output split_table_num_t split_entry_num
`ifdef GELATO_SPLIT_TABLE_ERR_EN
  , output logic           split_err
`endif
);

  logic [GELATO_WARP_NUM-1:0] pop_fire;
  logic [GELATO_WARP_NUM-1:0] full;
  thread_mask_t               lookup_mask [GELATO_WARP_NUM];
  split_table_num_t           push_num    [GELATO_WARP_NUM];
  logic                       id_active;
  logic                       split_fire;
`ifdef GELATO_SPLIT_TABLE_ERR_EN
  logic [GELATO_WARP_NUM-1:0] err_hit;
`endif

  assign id_active = id_valid & !id_stall;

  for (genvar w = 0; w < GELATO_WARP_NUM; w++) begin : g_warp
    gelato_split_stack u_stack (
      .clk            (clk),
      .rst_n          (rst_n),
      .lookup_idx     (id_split_table_num),
      .lookup_mask    (lookup_mask[w]),
      .pop_req        (id_active & (id_warp_num == warp_num_t'(w))),
      .pop_pc         (id_updated_pc),
      .pop_fire       (pop_fire[w]),
      .full           (full[w]),
      .push_en        (split_fire & (split_warp_num == warp_num_t'(w))),
      .push_mask      (split_mask),
      .push_pc        (split_reconv_pc),
      .push_entry_num (push_num[w])
`ifdef GELATO_SPLIT_TABLE_ERR_EN
      , .err_hit      (err_hit[w])
`endif
    );
  end

  assign id_thread_mask = lookup_mask[id_warp_num];

  // A reconvergence on the same warp wins; the branch unit retries its split.
  assign split_ready = !full[split_warp_num] & !pop_fire[split_warp_num];
  assign split_fire  = split_valid & split_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      split_done      <= 1'b0;
      split_entry_num <= '0;
    end else begin
      split_done <= split_fire;
      if (split_fire) begin
        split_entry_num <= push_num[split_warp_num];
      end
    end
  end

`ifdef GELATO_SPLIT_TABLE_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      split_err <= 1'b0;
    end else if (|err_hit) begin
      split_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gelato_split_table.sv
// tb/tb_gelato_split_table.sv - scoreboard bench for gelato_split_table
module tb_gelato_split_table;
  import gelato_types::*;

  logic             clk = 1'b0;
  logic             rst_n;
  warp_num_t        id_warp_num;
  split_table_num_t id_split_table_num;
  thread_mask_t     id_thread_mask;
  logic             id_valid;
  logic             id_stall;
  addr_t            id_updated_pc;
  logic             split_valid;
  logic             split_ready;
  warp_num_t        split_warp_num;
  thread_mask_t     split_mask;
  addr_t            split_reconv_pc;
  logic             split_done;
  split_table_num_t split_entry_num;
`ifdef GELATO_SPLIT_TABLE_ERR_EN
  logic             split_err;
`endif

  gelato_split_table dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .id_warp_num        (id_warp_num),
    .id_split_table_num (id_split_table_num),
    .id_thread_mask     (id_thread_mask),
    .id_valid           (id_valid),
    .id_stall           (id_stall),
    .id_updated_pc      (id_updated_pc),
    .split_valid        (split_valid),
    .split_ready        (split_ready),
    .split_warp_num     (split_warp_num),
    .split_mask         (split_mask),
    .split_reconv_pc    (split_reconv_pc),
    .split_done         (split_done),
    .split_entry_num    (split_entry_num)
`ifdef GELATO_SPLIT_TABLE_ERR_EN
    , .split_err        (split_err)
`endif
  );

  always #5 clk = ~clk;

  localparam int K_MASK  = 0;
  localparam int K_READY = 1;
  localparam int K_ERR   = 2;
  localparam int K_DONE  = 3;

  typedef struct {
    int          kind;
    logic [31:0] exp;
  } chk_t;

  chk_t chk_q[$];
  int   split_q[$];
  logic chk_strobe = 1'b0;
  int   checks = 0;
  int   errors = 0;

  function automatic string kind_name(input int k);
    case (k)
      K_MASK:  return "thread_mask";
      K_READY: return "split_ready";
      K_ERR:   return "split_err";
      default: return "split_done";
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    chk_t        c;
    logic [31:0] act;
    if (chk_strobe) begin
      checks++;
      if (chk_q.size() == 0) begin
        errors++;
        $display("FAIL check_queue: strobe with empty queue");
      end else begin
        c = chk_q.pop_front();
        case (c.kind)
          K_MASK:  act = id_thread_mask;
          K_READY: act = {31'd0, split_ready};
`ifdef GELATO_SPLIT_TABLE_ERR_EN
          K_ERR:   act = {31'd0, split_err};
`endif
          default: act = {31'd0, split_done};
        endcase
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s (w%0d idx%0d): got %h want %h", kind_name(c.kind),
                   id_warp_num, id_split_table_num, act, c.exp);
        end
      end
    end
    if (split_done === 1'b1) begin
      checks++;
      if (split_q.size() == 0) begin
        errors++;
        $display("FAIL split_done: unexpected pulse, entry_num got %0d want none", split_entry_num);
      end else begin
        int e;
        e = split_q.pop_front();
        if (int'(split_entry_num) != e) begin
          errors++;
          $display("FAIL split_entry_num: got %0d want %0d", split_entry_num, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input int kind, input logic [31:0] exp);
    chk_q.push_back('{kind: kind, exp: exp});
    chk_strobe = 1'b1;
    @(negedge clk);
    #1;
    chk_strobe = 1'b0;
  endtask

  task automatic expect_mask(input int w, input int idx, input logic [31:0] exp);
    id_warp_num        = warp_num_t'(w);
    id_split_table_num = split_table_num_t'(idx);
    expect_now(K_MASK, exp);
  endtask

  task automatic expect_ready(input int w, input logic exp);
    split_warp_num = warp_num_t'(w);
    expect_now(K_READY, {31'd0, exp});
  endtask

  task automatic do_split(input int w, input logic [31:0] m, input logic [31:0] pc, input int exp_num);
    split_warp_num  = warp_num_t'(w);
    split_mask      = m;
    split_reconv_pc = pc;
    split_valid     = 1'b1;
    split_q.push_back(exp_num);
    step();
    split_valid     = 1'b0;
  endtask

  task automatic set_pop(input int w, input int idx, input logic [31:0] pc, input logic stall);
    id_warp_num        = warp_num_t'(w);
    id_split_table_num = split_table_num_t'(idx);
    id_updated_pc      = pc;
    id_stall           = stall;
    id_valid           = 1'b1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stimulus
    id_warp_num = '0; id_split_table_num = '0; id_valid = 1'b0; id_stall = 1'b0;
    id_updated_pc = '0; split_valid = 1'b0; split_warp_num = '0; split_mask = '0;
    split_reconv_pc = '0; rst_n = 1'b0;
    apply_reset();

    // Reset state
    expect_mask(2, 0, 32'hFFFF_FFFF);
    expect_mask(2, 1, 32'h0000_0000);
    expect_ready(2, 1'b1);
    expect_now(K_DONE, 32'd0);

    // Basic split and pop on warp 1
    do_split(1, 32'h0000_00FF, 32'h100, 1);
    expect_mask(1, 0, 32'hFFFF_FF00);
    expect_mask(1, 1, 32'h0000_00FF);
    set_pop(1, 1, 32'h100, 1'b1);
    step();
    id_valid = 1'b0; id_stall = 1'b0;
    expect_mask(1, 0, 32'hFFFF_FF00);
    expect_mask(1, 1, 32'h0000_00FF);
    set_pop(1, 1, 32'h100, 1'b0);
    step();
    id_valid = 1'b0;
    expect_mask(1, 0, 32'hFFFF_FFFF);
    expect_mask(1, 1, 32'h0000_0000);

    // Degenerate splits leave the base entry untouched (also proves sp returned to 0)
    do_split(1, 32'h0000_0000, 32'h180, 0);
    do_split(1, 32'hFFFF_FFFF, 32'h190, 0);
    expect_mask(1, 0, 32'hFFFF_FFFF);
    expect_mask(1, 1, 32'h0000_0000);

    // Seven nested splits on warp 0 fill the table
    for (int k = 1; k <= 7; k++) begin
      do_split(0, 32'h7F >> (k - 1), 32'h200 + k, k);
    end
    expect_mask(0, 0, 32'hFFFF_FF80);
    expect_mask(0, 1, 32'h0000_0040);
    expect_mask(0, 6, 32'h0000_0002);
    expect_mask(0, 7, 32'h0000_0001);
    split_valid = 1'b1; split_mask = 32'h1;
    expect_ready(0, 1'b0);
    split_valid = 1'b0;
    set_pop(0, 5, 32'h205, 1'b0);
    step();
    id_valid = 1'b0;
    expect_mask(0, 5, 32'h0000_0004);
    expect_ready(0, 1'b0);
    set_pop(0, 7, 32'h207, 1'b0);
    step();
    id_valid = 1'b0;
    expect_mask(0, 6, 32'h0000_0003);
    expect_mask(0, 7, 32'h0000_0000);
    expect_ready(0, 1'b1);

    // Same-warp collision on warp 3: pop wins, split not accepted
    do_split(3, 32'h0000_000F, 32'h300, 1);
    set_pop(3, 1, 32'h300, 1'b0);
    split_mask = 32'h1; split_reconv_pc = 32'h380; split_valid = 1'b1;
    expect_ready(3, 1'b0);
    step();
    split_valid = 1'b0; id_valid = 1'b0;
    expect_mask(3, 0, 32'hFFFF_FFFF);
    expect_mask(3, 1, 32'h0000_0000);

    // Cross-warp: pop warp 3 and split warp 0 commit together
    do_split(3, 32'h0000_00F0, 32'h310, 1);
    set_pop(3, 1, 32'h310, 1'b0);
    split_mask = 32'h1; split_reconv_pc = 32'h2F0; split_valid = 1'b1;
    expect_ready(0, 1'b1);
    split_q.push_back(7);
    step();
    split_valid = 1'b0; id_valid = 1'b0;
    expect_mask(3, 0, 32'hFFFF_FFFF);
    expect_mask(3, 1, 32'h0000_0000);
    expect_mask(0, 6, 32'h0000_0002);
    expect_mask(0, 7, 32'h0000_0001);

    // Reset right after acceptance: the pending split_done must not appear
    split_warp_num = warp_num_t'(1); split_mask = 32'hF; split_reconv_pc = 32'h500;
    split_valid = 1'b1;
    step();
    rst_n = 1'b0; split_valid = 1'b0;
    expect_now(K_DONE, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    expect_mask(1, 1, 32'h0000_0000);
    expect_mask(0, 0, 32'hFFFF_FFFF);
    expect_mask(0, 7, 32'h0000_0000);

`ifdef GELATO_SPLIT_TABLE_ERR_EN
    expect_now(K_ERR, 32'd0);
    do_split(2, 32'h0000_000F, 32'h400, 1);
    do_split(2, 32'h0000_0003, 32'h410, 2);
    set_pop(2, 1, 32'h400, 1'b0);
    step();
    id_valid = 1'b0;
    expect_now(K_ERR, 32'd1);
    expect_mask(2, 1, 32'h0000_000C);
    expect_mask(2, 2, 32'h0000_0003);
    repeat (3) step();
    expect_now(K_ERR, 32'd1);
    apply_reset();
    expect_now(K_ERR, 32'd0);
`endif

    repeat (3) step();
    checks++;
    if (split_q.size() != 0 || chk_q.size() != 0) begin
      errors++;
      $display("FAIL drain: split_q left %0d chk_q left %0d, want 0 0", split_q.size(), chk_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gelato_split_table.md
Name: gelato_split_table

Overview:
- Per-warp SIMT divergence table; it is the stage directly downstream of I-Decode on the I-Decode/Split Table interface.
- I-Decode supplies warp, split entry index, valid, stall and updated PC. The table returns the active thread mask combinationally.
- The branch unit pushes splits into the table. Reconvergence pops entries and restores the parent mask.

Parameters:
- WARP_NUM, 4, number of warps (warp_num_t width = clog2).
- THREAD_NUM, 32, threads per warp (thread_mask_t width).
- SPLIT_DEPTH, 8, entries per warp, including base entry 0 (split_table_num_t width = clog2).
- ADDR_WIDTH, 32, PC width (addr_t).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- id_warp_num  in  clog2(WARP_NUM)  warp being decoded.
- id_split_table_num  in  clog2(SPLIT_DEPTH)  entry index the warp is executing under.
- id_thread_mask  out  THREAD_NUM  mask of the selected entry (combinational).
- id_valid  in  1  decoded instruction valid.
- id_stall  in  1  I-Decode stalled; no state update this cycle.
- id_updated_pc  in  ADDR_WIDTH  next PC of the warp.
- split_valid  in  1  branch unit split request.
- split_ready  out  1  split accepted this cycle when valid&ready.
- split_warp_num  in  clog2(WARP_NUM)  warp that diverged.
- split_mask  in  THREAD_NUM  threads taking the divergent path.
- split_reconv_pc  in  ADDR_WIDTH  reconvergence PC.
- split_done  out  1  one-cycle pulse, one cycle after acceptance.
- split_entry_num  out  clog2(SPLIT_DEPTH)  entry the divergent threads run under; valid with split_done.

Behaviour:
- Reset (async, rst_n=0):
  - Per warp: sp=0; entry0 valid, mask all ones, reconv_pc 0; entries 1..DEPTH-1 invalid, mask 0.
  - split_done=0, split_entry_num=0.
  - id_thread_mask follows the table: all ones for index 0.
  - Reset mid-operation discards all entries; no pending split_done survives.
- Lookup: id_thread_mask = entry[id_warp_num][id_split_table_num].mask if that entry is valid, else 0. Zero latency; independent of id_valid.
- Pop (qualified): id_valid & !id_stall & idx!=0 & entry valid & idx==sp[warp] & id_updated_pc==entry.reconv_pc.
  - Next edge: parent (idx-1).mask |= entry.mask; entry invalidated; sp decrements.
  - Non-top or non-matching requests are ignored.
- Push:
  - split_ready = (sp[split_warp_num] != SPLIT_DEPTH-1) & !(pop qualified for the same warp this cycle). Pop wins a same-warp collision; split is retried.
  - On accept, with P = top entry, eff = split_mask & P.mask:
    - eff==0 or eff==P.mask (degenerate): no state change; split_entry_num = sp.
    - Otherwise: entry sp+1 ← {valid, eff, split_reconv_pc}; P.mask &= ~eff; sp increments; split_entry_num = sp+1.
  - split_done pulses the next cycle.
- Push and pop on different warps in the same cycle both commit.
- Full table (sp==DEPTH-1): split_ready=0 until a pop occurs.
- id_stall=1 blocks pops only; lookup and push are unaffected.

Optional Feature:
- GELATO_SPLIT_TABLE_ERR_EN defined: adds output split_err (1 bit, sticky, reset 0). It sets on either:
  - a qualified-looking pop (id_valid & !id_stall & PC match) on a valid non-top entry, or
  - id_valid & !id_stall lookup of an invalid entry.
- Undefined: no port; these cases are silently ignored.

Decomposition:
- gelato_types holds: warp_num_t, split_table_num_t, thread_mask_t, addr_t, split_entry_t struct {valid, mask, reconv_pc}, GELATO_SPLIT_DEPTH.
- Sub-module gelato_split_stack: one per warp via generate. Owns sp, entries, push/pop and the degenerate check.
- The top level does warp decode, ready arbitration, lookup mux and the split_done register.

Test Plan:
- Reset, lookup warp 2 idx 0 → mask 0xFFFF_FFFF; idx 1 → 0; split_ready=1.
- Warp 1 split mask 0x0000_00FF, reconv 0x100 → split_done next cycle, entry_num=1. Idx0 mask 0xFFFF_FF00; idx1 mask 0x0000_00FF.
- Warp 1 idx1, id_valid, pc 0x100 → next cycle idx0 = 0xFFFF_FFFF, idx1 = 0, sp=0. Same with id_stall=1 → no change.
- Split mask 0 or 0xFFFF_FFFF on base → split_entry_num=0, masks unchanged. Seven nested splits on warp 0 → split_ready=0 at sp=7; a pop reopens it.
- Same-cycle pop and split on warp 3 → split_ready=0, pop commits. Split warp 0 with pop warp 3 → both commit.
- ERR_EN: pop at reconv PC on idx1 while sp=2 → split_err=1, sticky until reset; table unchanged.
